fir_tap_scheduler: RTL and testbench
====================================

// Module: fir_tap_scheduler
// PURPOSE
// - Controller that sequences the FIR MAC datapath (FIR_Logic-style: X, tap in; accumulated Y out).
// - Accepts one input sample per handshake and stores it in a circular data RAM of NUM_TAPS words.
// - Walks all taps, feeding the external MAC one product per cycle, then returns y and counts samples to len.
// - Sits between the AXI-Stream/AXI-Lite shims and the tap RAM, data RAM and MAC.
// PARAMETERS
// - NUM_TAPS  11  filter length; tap and data RAM depth
// - DATA_W    32  sample, tap and y width
// - ACC_W     68  MAC accumulator width
// - ADDR_W    4   RAM word-address width; 2**ADDR_W >= NUM_TAPS
// PORTS
// - CLK        in   1       clock; one clock domain.
// - Reset      in   1       reset, asynchronous and active-high.
// - ap_start   in   1       start request; sampled only in IDLE.
// - len        in   32      number of samples to process; latched on start.
// - busy       out  1       high in every state except IDLE.
// - ap_done    out  1       one-cycle pulse when the run completes.
// - x_valid    in   1       input sample valid.
// - x_ready    out  1       high only in WAIT_X.
// - x_data     in   DATA_W  input sample.
// - y_valid    out  1       output valid; held until y_ready.
// - y_ready    in   1       output accept.
// - y_data     out  DATA_W  filter output.
// - tap_addr   out  ADDR_W  tap RAM read address; synchronous RAM, 1-cycle read latency.
// - tap_rdata  in   DATA_W  tap RAM read data.
// - dat_we     out  1       data RAM write enable.
// - dat_addr   out  ADDR_W  data RAM address; shared by read and write.
// - dat_wdata  out  DATA_W  data RAM write data.
// - dat_rdata  in   DATA_W  data RAM read data; 1-cycle read latency.
// - mac_clr    out  1       clears the MAC accumulator at the next edge.
// - mac_en     out  1       accumulates mac_x*mac_tap at the next edge.
// - mac_x      out  DATA_W  MAC sample operand; equals dat_rdata.
// - mac_tap    out  DATA_W  MAC tap operand; equals tap_rdata.
// - mac_acc    in   ACC_W   MAC accumulator; registered.
// BEHAVIOUR
// - Reset value of every output is 0: FSM enters IDLE, ptr=0, count=0.
// - Reset applied mid-run aborts the run. RAM contents are then undefined; the next start re-clears them.
// - FSM states: IDLE, INIT, WAIT_X, MAC, DRAIN, OUT, DONE.
// - IDLE -> INIT on ap_start. len is latched here. ap_start in any other state is ignored.
// - INIT: NUM_TAPS cycles with dat_we=1, dat_wdata=0, dat_addr=0..NUM_TAPS-1.
// - INIT exits to DONE if len==0, otherwise to WAIT_X.
// - WAIT_X: x_ready=1. Stalls indefinitely while x_valid=0.
// - WAIT_X handshake cycle t: dat_we=1, dat_addr=ptr, dat_wdata=x_data, mac_clr=1. Next state MAC.
// - MAC: NUM_TAPS issue cycles t+1..t+NUM_TAPS.
//   - Issue k drives tap_addr=k and dat_addr=(ptr-k) mod NUM_TAPS (wrapping down-counter).
//   - mac_en=1 on cycles t+2..t+NUM_TAPS+1, one cycle after each issue.
// - DRAIN: one cycle covering the last mac_en. The next state is OUT.
// - OUT: y_valid=1 from cycle t+NUM_TAPS+2; latency is NUM_TAPS+2 cycles from the x handshake.
//   - y_data is stable while y_valid && !y_ready.
// - On the y handshake: ptr wraps NUM_TAPS-1 -> 0 and count increments.
//   - If count+1==len the next state is DONE, otherwise WAIT_X.
// - DONE: ap_done=1 for exactly one cycle, then IDLE.
// - Arithmetic: default y_data = mac_acc[DATA_W-1:0], i.e. truncation with two's-complement wrap.
// - mac_clr and mac_en are never high in the same cycle.
// CONFIGURATION
// - FIR_SCHED_SAT_EN defined: mac_acc is treated as signed.
//   - y_data saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
// - FIR_SCHED_SAT_EN undefined: y_data is plain truncation as above. No other behaviour differs.
// TESTING
// - Reset: assert Reset mid-stream -> all outputs 0 within the same cycle, busy=0, FSM in IDLE.
// - Impulse: taps 1..11, len=12, x=1 then eleven 0s, y_ready=1.
//   - Expected y=1,2,...,11,0; one ap_done pulse after the 12th y handshake.
// - Latency/backpressure: y_ready low 5 cycles -> y_valid held, y_data stable, x_ready=0.
//   - Handshake occurs on the first y_ready=1 cycle.
//   - Between that x handshake and y_valid: exactly 13 cycles; mac_en high for exactly 11 cycles.
// - Wrap: len=25, x=1..25, taps all 1.
//   - y[n] = sum of the last 11 samples; y[24]=15+...+25=220. ptr wraps twice.
// - Edge: len=0 -> INIT runs 11 clear cycles, then ap_done pulses; x_ready stays 0.
//   - ap_start during busy is ignored.
// - FIR_SCHED_SAT_EN: taps=x=32'h7FFFFFFF, len=1.
//   - With the macro: y=32'h7FFFFFFF.
//   - Without the macro: y = low 32 bits of 11*(2**31-1)**2.

Source files
------------

// File: rtl/fir_tap_scheduler.sv
// Sequencer for an FIR MAC datapath: clears the data RAM, stores each sample, issues one tap product per cycle, returns y.
// Define FIR_SCHED_SAT_EN to saturate y_data from a signed accumulator; otherwise y_data is the truncated accumulator.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ap_start; len latched on start
// INIT    | zero the data RAM, one word per cycle
// WAIT_X  | x_ready high; handshake writes sample and clears the MAC
// MAC     | NUM_TAPS issue cycles of tap/data RAM reads
// DRAIN   | last accumulate of the final product
// OUT     | y_valid held until y_ready
// DONE    | one-cycle ap_done pulse
module fir_tap_scheduler #(
  parameter int NUM_TAPS = 11,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 68,
  parameter int ADDR_W   = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ap_start,
  input  logic [31:0]       len,
  output logic              busy,
  output logic              ap_done,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic [ADDR_W-1:0] tap_addr,
  input  logic [DATA_W-1:0] tap_rdata,
  output logic              dat_we,
  output logic [ADDR_W-1:0] dat_addr,
  output logic [DATA_W-1:0] dat_wdata,
  input  logic [DATA_W-1:0] dat_rdata,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_x,
  output logic [DATA_W-1:0] mac_tap,
  input  logic [ACC_W-1:0]  mac_acc
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_X, S_MAC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       count_q, count_d;
  logic [DATA_W-1:0] y_res;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // Accumulator to output word; only consumed in OUT.
  always_comb begin
`ifdef FIR_SCHED_SAT_EN
    if ((&mac_acc[ACC_W-1:DATA_W-1]) || (~|mac_acc[ACC_W-1:DATA_W-1]))
      y_res = mac_acc[DATA_W-1:0];
    else if (mac_acc[ACC_W-1])
      y_res = {1'b1, {(DATA_W-1){1'b0}}};
    else
      y_res = {1'b0, {(DATA_W-1){1'b1}}};
`else
    y_res = mac_acc[DATA_W-1:0];
`endif
  end

`ifndef FIR_SCHED_SAT_EN
  logic unused_acc_hi;
  assign unused_acc_hi = ^mac_acc[ACC_W-1:DATA_W];
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    len_d     = len_q;
    count_d   = count_q;
    busy      = (state_q != S_IDLE);
    ap_done   = 1'b0;
    x_ready   = 1'b0;
    y_valid   = 1'b0;
    y_data    = '0;
    tap_addr  = '0;
    dat_we    = 1'b0;
    dat_addr  = '0;
    dat_wdata = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d   = len;
          ptr_d   = '0;
          count_d = '0;
          cnt_d   = LAST;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        dat_we   = 1'b1;
        dat_addr = LAST - cnt_q;
        if (cnt_q == '0)
          state_d = (len_q == 32'd0) ? S_DONE : S_WAIT_X;
        else
          cnt_d = cnt_q - A_ONE;
      end
      S_WAIT_X: begin
        x_ready = 1'b1;
        if (x_valid) begin
          dat_we    = 1'b1;
          dat_addr  = ptr_q;
          dat_wdata = x_data;
          mac_clr   = 1'b1;
          cnt_d     = LAST;
          rd_d      = ptr_q;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        // Read data lands one cycle after issue, so the first issue cycle has no accumulate.
        tap_addr = LAST - cnt_q;
        dat_addr = rd_q;
        mac_en   = (cnt_q != LAST);
        rd_d     = (rd_q == '0) ? LAST : rd_q - A_ONE;
        if (cnt_q == '0)
          state_d = S_DRAIN;
        else
          cnt_d = cnt_q - A_ONE;
      end
      S_DRAIN: begin
        mac_en  = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        y_valid = 1'b1;
        y_data  = y_res;
        if (y_ready) begin
          ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + A_ONE;
          count_d = count_q + 32'd1;
          state_d = ((count_q + 32'd1) == len_q) ? S_DONE : S_WAIT_X;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mac_x   = mac_en ? dat_rdata : '0;
    mac_tap = mac_en ? tap_rdata : '0;
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Scoreboard bench for fir_tap_scheduler: RAM and MAC models around the DUT, expected y from a sample-history model.
`timescale 1ns/1ps
module tb_fir_tap_scheduler;
  localparam int N   = 11;
  localparam int DW  = 32;
  localparam int AW  = 68;
  localparam int ADW = 4;

  logic           CLK = 1'b0;
  logic           Reset;
  logic           ap_start;
  logic [31:0]    len;
  logic           busy, ap_done;
  logic           x_valid, x_ready;
  logic [DW-1:0]  x_data;
  logic           y_valid;
  logic           y_ready;
  logic [DW-1:0]  y_data;
  logic [ADW-1:0] tap_addr, dat_addr;
  logic [DW-1:0]  tap_rdata, dat_rdata, dat_wdata, mac_x, mac_tap;
  logic           dat_we, mac_clr, mac_en;
  logic [AW-1:0]  mac_acc;

  always #5 CLK = ~CLK;

  fir_tap_scheduler dut (
    .CLK(CLK), .Reset(Reset), .ap_start(ap_start), .len(len), .busy(busy), .ap_done(ap_done),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .tap_addr(tap_addr), .tap_rdata(tap_rdata),
    .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_x(mac_x), .mac_tap(mac_tap), .mac_acc(mac_acc)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [AW-1:0] sext_prod(logic [DW-1:0] a, logic [DW-1:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return {{(AW-64){p[63]}}, p};
  endfunction

  // External RAMs and MAC
  logic [DW-1:0] tap_mem [16];
  logic [DW-1:0] dat_mem [16];

  always @(posedge CLK) begin
    tap_rdata <= tap_mem[tap_addr];
    if (dat_we) dat_mem[dat_addr] <= dat_wdata;
    dat_rdata <= dat_mem[dat_addr];
  end

  always @(posedge CLK or posedge Reset) begin
    if (Reset)        mac_acc <= '0;
    else if (mac_clr) mac_acc <= '0;
    else if (mac_en)  mac_acc <= mac_acc + sext_prod(mac_x, mac_tap);
  end

  // Reference: y[n] = sum_k tap[k] * x[n-k] over this run's samples
  logic [DW-1:0] hist  [$];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] ref_y(int n);
    logic signed [AW-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++)
      if (n - k >= 0) acc = acc + sext_prod(tap_mem[k], hist[n-k]);
`ifdef FIR_SCHED_SAT_EN
    if (acc > $signed({36'd0, 32'h7FFFFFFF}))             return 32'h7FFFFFFF;
    else if (acc < $signed({36'hFFFFFFFFF, 32'h80000000})) return 32'h80000000;
    else                                                   return acc[DW-1:0];
`else
    return acc[DW-1:0];
`endif
  endfunction

  // y_ready driver: 0 = always ready, 1 = random, 2 = hold low for the first 5 valid cycles
  int yr_mode = 0;
  int age = 0;
  always @(posedge CLK) begin
    #1;
    if (y_valid) age++; else age = 0;
    case (yr_mode)
      1:       y_ready = 1'($urandom_range(0, 1));
      2:       y_ready = (age > 5);
      default: y_ready = 1'b1;
    endcase
  end

  // Monitor
  int            cyc = 0;
  int            xhs_cyc = 0;
  int            men_cnt = 0;
  int            stall = 0;
  int            done_cnt = 0;
  int            yhs_cnt = 0;
  logic [DW-1:0] last_y = '0;
  logic          pv_valid = 1'b0, pv_ready = 1'b0, pv_done = 1'b0;
  logic [DW-1:0] pv_data = '0;

  always @(negedge CLK) begin
    cyc++;
    if (Reset) begin
      pv_valid = 1'b0; pv_ready = 1'b0; pv_done = 1'b0; stall = 0;
    end else begin
      if (x_valid && x_ready) begin xhs_cyc = cyc; men_cnt = 0; end
      if (mac_en) men_cnt++;
      if (mac_en || mac_clr) chk("mac_clr_en_excl", {63'd0, mac_en & mac_clr}, 64'd0);
      if (y_valid && !pv_valid) begin
        chk("x_to_y_latency", 64'(cyc - xhs_cyc), 64'd13);
        chk("mac_en_cycles", 64'(men_cnt), 64'd11);
      end
      if (y_valid && pv_valid && !pv_ready) begin
        chk("y_data_stable", 64'(y_data), 64'(pv_data));
        chk("x_ready_in_stall", {63'd0, x_ready}, 64'd0);
      end
      if (pv_valid && pv_ready) chk("y_valid_drop", {63'd0, y_valid}, 64'd0);
      if (y_valid && !y_ready) stall++;
      if (y_valid && y_ready) begin
        if (yr_mode == 2) chk("bp_stall_cycles", 64'(stall), 64'd5);
        stall = 0;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL y_unexpected: got %0h, expected no output", y_data);
        end else begin
          chk("y_data", 64'(y_data), 64'(exp_q.pop_front()));
        end
        last_y = y_data;
        yhs_cnt++;
      end
      if (ap_done) begin
        done_cnt++;
        chk("done_pulse_width", {63'd0, pv_done}, 64'd0);
      end
      pv_valid = y_valid; pv_ready = y_ready; pv_done = ap_done; pv_data = y_data;
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_run(input int l);
    hist.delete();
    ap_start = 1'b1; len = 32'(l);
    tick();
    ap_start = 1'b0;
  endtask

  task automatic send_x(input logic [DW-1:0] v, input int gap);
    int w;
    w = 0;
    repeat (gap) tick();
    x_valid = 1'b1; x_data = v;
    forever begin
      @(negedge CLK);
      if (x_ready) break;
      w++;
      if (w > 500) break;
    end
    if (!x_ready) begin
      n_vec++; n_bad++;
      $display("FAIL x_wait_timeout: x_ready low for %0d cycles, expected a handshake", w);
    end else begin
      hist.push_back(v);
      exp_q.push_back(ref_y(hist.size() - 1));
    end
    tick();
    x_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] xval(int mode, int i);
    case (mode)
      0:       return (i == 0) ? 32'd1 : 32'd0;
      1:       return 32'(i + 1);
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input int l, input int mode, input int gapmax);
    int d0, y0, w;
    d0 = done_cnt; y0 = yhs_cnt;
    start_run(l);
    for (int i = 0; i < l; i++) send_x(xval(mode, i), $urandom_range(0, gapmax));
    w = 0;
    while (done_cnt == d0 && w < 3000) begin @(negedge CLK); w++; end
    if (done_cnt == d0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: no ap_done after %0d cycles, expected one pulse", w);
    end else begin
      chk("y_handshakes", 64'(yhs_cnt - y0), 64'(l));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
    end
    tick();
    @(negedge CLK);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctrl"}, {56'd0, busy, ap_done, x_ready, y_valid, dat_we, mac_clr, mac_en, 1'b0}, 64'd0);
    chk({tag, "_y_data"}, 64'(y_data), 64'd0);
    chk({tag, "_addrs"}, {56'd0, tap_addr, dat_addr}, 64'd0);
    chk({tag, "_wdata"}, 64'(dat_wdata), 64'd0);
    chk({tag, "_mac_ops"}, {mac_x, mac_tap}, 64'd0);
  endtask

  initial begin
    int d0, nclr;
    logic xr_seen;
    Reset = 1'b1; ap_start = 1'b0; len = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
    for (int i = 0; i < 16; i++) tap_mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    Reset = 1'b0;
    tick();

    // Impulse: taps 1..11 give y = 1..11 then 0
    for (int i = 0; i < N; i++) tap_mem[i] = 32'(i + 1);
    run(12, 0, 0);
    chk("impulse_last_y", 64'(last_y), 64'd0);

    // Backpressure on every output
    for (int i = 0; i < N; i++) tap_mem[i] = $urandom;
    yr_mode = 2;
    run(3, 2, 1);
    yr_mode = 0;

    // Wrap: 25 samples through an 11-deep buffer
    for (int i = 0; i < N; i++) tap_mem[i] = 32'd1;
    run(25, 1, 0);
    chk("wrap_y24", 64'(last_y), 64'd220);

    // len = 0: clears only, ap_start during the run ignored
    d0 = done_cnt; nclr = 0; xr_seen = 1'b0;
    ap_start = 1'b1; len = '0;
    tick();
    ap_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      ap_start = (c == 3);
      if (dat_we) begin
        chk("init_addr", 64'(dat_addr), 64'(nclr));
        chk("init_wdata", 64'(dat_wdata), 64'd0);
        nclr++;
      end
      if (x_ready) xr_seen = 1'b1;
    end
    ap_start = 1'b0;
    chk("init_clear_cycles", 64'(nclr), 64'd11);
    chk("len0_x_ready", {63'd0, xr_seen}, 64'd0);
    chk("len0_done_count", 64'(done_cnt - d0), 64'd1);
    chk("len0_busy", {63'd0, busy}, 64'd0);
    tick();

    // Large operands: truncation vs saturation
    for (int i = 0; i < N; i++) tap_mem[i] = 32'h7FFFFFFF;
    run(11, 3, 0);
`ifdef FIR_SCHED_SAT_EN
    chk("sat_y10", 64'(last_y), 64'h7FFFFFFF);
`else
    chk("trunc_y10", 64'(last_y), 64'd11);
`endif

    // Random runs with random gaps and y_ready
    yr_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) tap_mem[i] = $urandom;
      run($urandom_range(1, 6), 2, 3);
    end
    yr_mode = 0;

    // Reset mid-run, then recover
    for (int i = 0; i < N; i++) tap_mem[i] = $urandom;
    start_run(5);
    send_x($urandom, 0);
    repeat (4) tick();
    Reset = 1'b1;
    #1;
    chk_zero("midrun_reset");
    exp_q.delete();
    hist.delete();
    tick();
    Reset = 1'b0;
    tick();
    run(3, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
